// File: rtl/param_datapath_pkg.sv
// Shared opcodes, FSM encoding and instruction field helpers for param_datapath.
// Field helpers take the data width and register-address width as arguments.
package param_datapath_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_JNZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    // Word layout, MSB first: op[2:0], rd[ra], rs[ra], imm[width]
    function automatic logic [2:0] f_op(input logic [63:0] ins,
                                        input int width, input int ra);
        return 3'(ins >> (width + 2 * ra));
    endfunction

    function automatic logic [31:0] f_rd(input logic [63:0] ins,
                                         input int width, input int ra);
        return 32'(ins >> (width + ra)) & ((32'd1 << ra) - 32'd1);
    endfunction

    function automatic logic [31:0] f_rs(input logic [63:0] ins,
                                         input int width, input int ra);
        return 32'(ins >> width) & ((32'd1 << ra) - 32'd1);
    endfunction

    function automatic logic [63:0] f_imm(input logic [63:0] ins,
                                          input int width);
        return ins & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/param_datapath_regfile.sv
// NUM_REGS x WIDTH register file: one write port, two combinational reads,
// async active-high reset and a flattened view with R0 in the low bits.
module dp_regfile
    import param_datapath_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int NUM_REGS = 4,
    parameter int RA       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [RA-1:0]             waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [RA-1:0]             raddr_a_i,
    input  logic [RA-1:0]             raddr_b_i,
    output logic [WIDTH-1:0]          rdata_a_o,
    output logic [WIDTH-1:0]          rdata_b_o,
    output logic [NUM_REGS*WIDTH-1:0] regs_o
);

    logic [WIDTH-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*WIDTH +: WIDTH] = mem_q[g];
    end

endmodule

// File: rtl/param_datapath.sv
// Parametrised fetch/execute datapath: PC, 4-state FSM, register file, ALU.
// Define SINGLE_STEP_EN to add the step input (one instruction per pulse).
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int  WIDTH    = 4,
    parameter int  NUM_REGS = 4,
    parameter int  PC_W     = 4,
    localparam int RA       = $clog2(NUM_REGS),
    localparam int INS_W    = 3 + 2 * RA + WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_pc,
    input  logic [PC_W-1:0]           start_pc,
    input  logic                      run_en,
`ifdef SINGLE_STEP_EN
    input  logic                      step,
`endif
    output logic                      ins_rd_en,
    output logic [PC_W-1:0]           ins_addr,
    input  logic [INS_W-1:0]          ins_data,
    output logic [NUM_REGS*WIDTH-1:0] regs,
    output logic                      carry,
    output logic                      halted
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic             carry_q, carry_d;

    logic [2:0]       op;
    logic [RA-1:0]    rd_idx, rs_idx;
    logic [WIDTH-1:0] imm_w, rd_val, rs_val;
    logic [PC_W-1:0]  jmp_tgt;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             go, cont;

    assign op      = f_op(64'(ins_data), WIDTH, RA);
    assign rd_idx  = RA'(f_rd(64'(ins_data), WIDTH, RA));
    assign rs_idx  = RA'(f_rs(64'(ins_data), WIDTH, RA));
    assign imm_w   = WIDTH'(f_imm(64'(ins_data), WIDTH));
    assign jmp_tgt = PC_W'(imm_w);

`ifdef SINGLE_STEP_EN
    assign go   = run_en && step;
    assign cont = 1'b0;
`else
    assign go   = run_en;
    assign cont = run_en;
`endif

    dp_regfile #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .RA       (RA)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wr_en),
        .waddr_i   (rd_idx),
        .wdata_i   (wr_data),
        .raddr_a_i (rd_idx),
        .raddr_b_i (rs_idx),
        .rdata_a_o (rd_val),
        .rdata_b_o (rs_val),
        .regs_o    (regs)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        carry_d = carry_q;
        wr_en   = 1'b0;
        wr_data = rd_val;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_FETCH;
            end
            S_FETCH: begin
                addr_d  = pc_q;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d = pc_q + PC_W'(1);
                case (op)
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = imm_w;
                    end
                    OP_ADD: begin
                        wr_en = 1'b1;
                        {carry_d, wr_data} = {1'b0, rd_val} + {1'b0, rs_val};
                    end
                    // Top bit of the widened difference is the borrow
                    OP_SUB: begin
                        wr_en = 1'b1;
                        {carry_d, wr_data} = {1'b0, rd_val} - {1'b0, rs_val};
                    end
                    OP_AND: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val & rs_val;
                    end
                    OP_MOV: begin
                        wr_en   = 1'b1;
                        wr_data = rs_val;
                    end
                    OP_JNZ: begin
                        if (rd_val != '0) pc_d = jmp_tgt;
                    end
                    OP_HALT: begin
                        pc_d = pc_q;
                    end
                    default: ;
                endcase
                if (op == OP_HALT) state_d = S_HALT;
                else if (cont)     state_d = S_FETCH;
                else               state_d = S_IDLE;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
        // set_pc overrides everything, including an in-flight EXEC
        if (set_pc) begin
            pc_d    = start_pc;
            state_d = S_IDLE;
            wr_en   = 1'b0;
            carry_d = carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            carry_q <= carry_d;
        end
    end

    assign ins_rd_en = (state_q == S_FETCH);
    assign ins_addr  = ins_rd_en ? pc_q : addr_q;
    assign carry     = carry_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath (default parameters) with an external
// synchronous ROM model; covers the step input when SINGLE_STEP_EN is set.
module tb_param_datapath;

    logic        clk;
    logic        rst;
    logic        set_pc;
    logic [3:0]  start_pc;
    logic        run_en;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif
    logic        ins_rd_en;
    logic [3:0]  ins_addr;
    logic [10:0] ins_data;
    logic [15:0] regs;
    logic        carry;
    logic        halted;

    logic [10:0] rom [16];
    logic [3:0]  addr_log [$];
    int          checks;
    int          failures;

    localparam logic [2:0] NOP = 3'b000, LDI = 3'b001, ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011, JNZ = 3'b110, HLT = 3'b111;

    param_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .set_pc    (set_pc),
        .start_pc  (start_pc),
        .run_en    (run_en),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .ins_rd_en (ins_rd_en),
        .ins_addr  (ins_addr),
        .ins_data  (ins_data),
        .regs      (regs),
        .carry     (carry),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ins_rd_en) ins_data <= rom[ins_addr];
    end

    always @(negedge clk) begin
        if (ins_rd_en) addr_log.push_back(ins_addr);
    end

    function automatic logic [10:0] enc(input logic [2:0] op, input int rd,
                                        input int rs, input int imm);
        return {op, 2'(rd), 2'(rs), 4'(imm)};
    endfunction

    function automatic logic [3:0] r(input int i);
        return regs[i*4 +: 4];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_pc(input logic [3:0] s);
        addr_log.delete();
        set_pc   = 1'b1;
        start_pc = s;
        @(negedge clk);
        set_pc   = 1'b0;
    endtask

    task automatic run_prog(input logic [3:0] s, input int maxc);
        load_pc(s);
        run_en = 1'b1;
        for (int i = 0; i < maxc && !halted; i++) @(negedge clk);
        run_en = 1'b0;
        check("halt_reached", halted, 1);
    endtask

    task automatic wait_fetch();
        for (int i = 0; i < 20 && !ins_rd_en; i++) @(negedge clk);
        check("fetch_seen", ins_rd_en, 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_pc   = 1'b0;
        start_pc = '0;
        run_en   = 1'b0;
        ins_data = '0;
`ifdef SINGLE_STEP_EN
        step     = 1'b1;
`endif
        for (int i = 0; i < 16; i++) rom[i] = enc(NOP, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_regs", regs, 0);
        check("rst_carry", carry, 0);
        check("rst_halted", halted, 0);
        check("rst_rd_en", ins_rd_en, 0);
        check("rst_addr", ins_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // start at 2: LDI R0,9 ; HALT
        rom[2] = enc(LDI, 0, 0, 9);
        rom[3] = enc(HLT, 0, 0, 0);
        run_prog(4'd2, 20);
        check("t2_log_n", addr_log.size(), 2);
        check("t2_log0", addr_log[0], 2);
        check("t2_log1", addr_log[1], 3);
        check("t2_r0", r(0), 9);
        repeat (3) @(negedge clk);
        check("t2_still_halt", halted, 1);
        check("t2_addr_hold", ins_addr, 3);
        check("t2_no_fetch", addr_log.size(), 2);

        // LDI R1,12 ; LDI R2,7 ; ADD R1,R2 ; HALT
        rom[4] = enc(LDI, 1, 0, 12);
        rom[5] = enc(LDI, 2, 0, 7);
        rom[6] = enc(ADD, 1, 2, 0);
        rom[7] = enc(HLT, 0, 0, 0);
        run_prog(4'd4, 30);
        check("add_r1", r(1), 3);
        check("add_r2", r(2), 7);
        check("add_carry", carry, 1);

        rom[8] = enc(SUB, 2, 1, 0);
        rom[9] = enc(HLT, 0, 0, 0);
        run_prog(4'd8, 20);
        check("sub1_r2", r(2), 4);
        check("sub1_carry", carry, 0);

        rom[10] = enc(SUB, 1, 2, 0);
        rom[11] = enc(HLT, 0, 0, 0);
        run_prog(4'd10, 20);
        check("sub2_r1", r(1), 15);
        check("sub2_carry", carry, 1);

        // async reset in the middle of EXEC of LDI R1,5
        rom[0] = enc(LDI, 1, 0, 5);
        load_pc(4'd0);
        run_en = 1'b1;
        wait_fetch();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_regs", regs, 0);
        check("mid_rst_carry", carry, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_rd_en", ins_rd_en, 0);
        run_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_nowr", r(1), 0);
        check("mid_rst_idle", ins_rd_en, 0);

        // countdown loop: JNZ taken twice, then falls through to HALT
        rom[0] = enc(LDI, 3, 0, 1);
        rom[1] = enc(LDI, 0, 0, 3);
        rom[2] = enc(SUB, 0, 3, 0);
        rom[3] = enc(JNZ, 0, 0, 2);
        rom[4] = enc(HLT, 0, 0, 0);
        run_prog(4'd0, 60);
        begin
            logic [3:0] exp_log [9] = '{0, 1, 2, 3, 2, 3, 2, 3, 4};
            check("loop_log_n", addr_log.size(), 9);
            for (int i = 0; i < 9 && i < addr_log.size(); i++)
                check($sformatf("loop_log%0d", i), addr_log[i], exp_log[i]);
        end
        check("loop_r0", r(0), 0);
        check("loop_r3", r(3), 1);
        check("loop_carry", carry, 0);
        check("loop_addr", ins_addr, 4);

        // PC wrap 15 -> 0
        rom[15] = enc(NOP, 0, 0, 0);
        rom[0]  = enc(HLT, 0, 0, 0);
        run_prog(4'd15, 20);
        check("wrap_log_n", addr_log.size(), 2);
        check("wrap_log0", addr_log[0], 15);
        check("wrap_log1", addr_log[1], 0);

        // run_en dropped during FETCH of LDI R2,6
        rom[5] = enc(LDI, 2, 0, 6);
        rom[6] = enc(LDI, 1, 0, 7);
        load_pc(4'd5);
        run_en = 1'b1;
        wait_fetch();
        run_en = 1'b0;
        repeat (5) @(negedge clk);
        check("drop_r2", r(2), 6);
        check("drop_log_n", addr_log.size(), 1);
        check("drop_addr_hold", ins_addr, 5);
        check("drop_halted", halted, 0);

        // set_pc during EXEC of LDI R1,7 blocks the write
        load_pc(4'd6);
        run_en = 1'b1;
        wait_fetch();
        @(negedge clk);
        set_pc   = 1'b1;
        start_pc = 4'd0;
        run_en   = 1'b0;
        @(negedge clk);
        set_pc = 1'b0;
        check("setpc_nowr", r(1), 0);
        repeat (3) @(negedge clk);
        check("setpc_idle", ins_rd_en, 0);

`ifdef SINGLE_STEP_EN
        for (int i = 0; i < 4; i++) rom[i] = enc(LDI, 0, 0, i + 1);
        step = 1'b0;
        load_pc(4'd0);
        run_en = 1'b1;
        repeat (4) @(negedge clk);
        check("step_none", addr_log.size(), 0);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (4) @(negedge clk);
        end
        run_en = 1'b0;
        check("step_count", addr_log.size(), 3);
        check("step_r0", r(0), 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
- Parametrised successor to the fixed 4-bit, 4-register CPU datapath.
- Adds a program counter and a fetch/execute state machine driving a synchronous instruction memory.
- Adds an N-entry register file and a small ALU. Data width, register count and PC width are all generic.
- The testbench and top-level instantiate it between the oscillator-driven clock and an external instruction ROM.

Parameters:
- WIDTH, 4: data/register width in bits.
- NUM_REGS, 4: register count (power of 2, at least 2); RA = clog2(NUM_REGS).
- PC_W, 4: PC and instruction-address width.
- INS_W, 3+2*RA+WIDTH: instruction word width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_pc  in  1  load start_pc into PC and abort any run.
- start_pc  in  PC_W  PC load value.
- run_en  in  1  allow fetch/execute; replaces the old en_ins_mem control.
- ins_rd_en  out  1  instruction memory read strobe.
- ins_addr  out  PC_W  instruction memory address.
- ins_data  in  INS_W  instruction word, valid exactly 1 cycle after a ins_rd_en cycle.
- regs  out  NUM_REGS*WIDTH  flattened register file; R0 occupies bits [WIDTH-1:0].
- carry  out  1  carry/borrow from the last ADD/SUB.
- halted  out  1  high in the HALT state.

Behaviour:
- Reset (async, rst=1): PC=0, all registers=0, carry=0, state=IDLE, ins_rd_en=0, ins_addr=0, halted=0.
- Instruction fields, MSB first: op[2:0], rd[RA], rs[RA], imm[WIDTH].
- Opcodes:
  - 000 NOP.
  - 001 LDI: rd=imm.
  - 010 ADD: rd=rd+rs, carry=carry-out.
  - 011 SUB: rd=rd-rs, carry=borrow.
  - 100 AND: rd=rd&rs.
  - 101 MOV: rd=rs.
  - 110 JNZ: if rd!=0 then PC=imm[PC_W-1:0] (zero-extended if PC_W>WIDTH), else PC+1.
  - 111 HALT.
- Arithmetic is mod 2^WIDTH. carry changes only on ADD/SUB.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE: if run_en then go to FETCH.
  - FETCH: ins_rd_en=1, ins_addr=PC for exactly this cycle; next state EXEC.
  - EXEC: decode ins_data, write rd (and carry) at the end of the cycle, update PC (PC+1 or jump target).
    - op=HALT: go to HALT; PC is not incremented.
    - else if run_en: go to FETCH.
    - else: go to IDLE.
  - HALT: halted=1; leave only on set_pc or rst.
- Timing: each instruction takes 2 cycles. A register update is visible on regs the cycle after EXEC.
- PC wraps from 2^PC_W-1 to 0.
- set_pc has priority over every FSM transition. On set_pc: PC=start_pc next edge, state=IDLE, no register write that cycle even if in EXEC, halted clears.
- run_en dropped during FETCH: EXEC still completes, then the FSM goes to IDLE.
- ins_addr holds its last value when ins_rd_en=0.
- Unused imm bits and rs on LDI are ignored.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input step (1 bit).
  - IDLE goes to FETCH only on run_en && step.
  - EXEC always returns to IDLE (except HALT).
  - Result: exactly one instruction per step pulse. A step held high runs one instruction every 3 cycles.
- SINGLE_STEP_EN undefined: no step port; behaviour as above.

Decomposition:
- Package param_datapath_pkg holds:
  - opcode localparams OP_NOP..OP_HALT;
  - FSM state encoding;
  - field-slicing functions for op/rd/rs/imm given WIDTH/RA.
- One sub-module: dp_regfile. NUM_REGS x WIDTH, one write port, two combinational read ports, async reset, flattened output. ALU stays inline.

Test Plan:
- rst pulse mid-EXEC of "LDI R1,5" → regs=0, carry=0, halted=0 immediately, IDLE; no write of 5.
- set_pc=1, start_pc=2, then run_en=1 with ROM[2]=LDI R0,9, ROM[3]=HALT → ins_addr sequence 2,3; R0=9; halted=1; PC stays 3.
- LDI R1,12; LDI R2,7; ADD R1,R2 → R1=3, carry=1. Then SUB R2,R1 → R2=4, carry=0. Then SUB R1,R2 → R1=15, carry=1.
- Loop: LDI R0,3; SUB R0,R3 with R3=1; JNZ R0→1; HALT → JNZ taken twice, R0=0, halt at expected address.
- PC wrap: start_pc=15, ROM[15]=NOP, ROM[0]=HALT → ins_addr 15 then 0, halted=1.
- run_en dropped during FETCH of LDI R2,6 → R2=6 written, FSM in IDLE, no further ins_rd_en. With SINGLE_STEP_EN: three step pulses → exactly three instructions retired.
